// File: rtl/reu_pkg.sv
// Shared encodings for the REU DMA sequencer: transfer types and FSM states.
package reu_pkg;

  typedef enum logic [1:0] {
    XFER_STASH  = 2'b00,
    XFER_FETCH  = 2'b01,
    XFER_SWAP   = 2'b10,
    XFER_VERIFY = 2'b11
  } xfer_e;

  typedef enum logic [3:0] {
    IDLE  = 4'd0,
    ARB   = 4'd1,
    STASH = 4'd2,
    F_RD  = 4'd3,
    F_WR  = 4'd4,
    S_RD  = 4'd5,
    S_ST  = 4'd6,
    S_WR  = 4'd7,
    V_RD  = 4'd8,
    V_CMP = 4'd9
  } state_e;

endpackage

// File: rtl/reu_dma_sequencer.sv
// Per-bus-cycle REU DMA sequencer: arbitrates for the bus, then steps the
// stash/fetch/swap/verify transfer and emits BA-qualified register strobes.
module reu_dma_sequencer
  import reu_pkg::*;
#(
  parameter int unsigned START_DELAY = 1
) (
  input  logic       PHI2,
  input  logic       nRESET,
  input  logic       BA,
  input  logic       Execute,
  input  logic [1:0] XferType,
  input  logic       Length1,
  input  logic       Match,
  output logic       RAMRD,
  output logic       RAMWR,
  output logic       DMA,
  output logic       nWEDMA,
  output logic       RegReset,
  output logic       IncCA,
  output logic       IncREUA,
  output logic       DecLen,
  output logic       XferEnd,
  output logic       SetEndOfBlock,
  output logic       SetVerifyErr
);

  localparam logic [1:0] START_CNT = 2'(START_DELAY - 1);

  state_e     state_q, state_d;
  logic [1:0] cnt_q, cnt_d;
  logic       regreset_q;

  // Register state, start-delay counter and the one-edge register-file reset.
  always_ff @(posedge PHI2 or negedge nRESET) begin
    if (!nRESET) begin
      state_q    <= IDLE;
      cnt_q      <= 2'd0;
      regreset_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      regreset_q <= 1'b0;
    end
  end

  assign DMA      = (state_q != IDLE);
  assign RegReset = regreset_q;

  // Next state and strobe decode; every transfer state freezes while BA is low.
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    RAMRD         = 1'b0;
    RAMWR         = 1'b0;
    nWEDMA        = 1'b1;
    IncCA         = 1'b0;
    IncREUA       = 1'b0;
    DecLen        = 1'b0;
    XferEnd       = 1'b0;
    SetEndOfBlock = 1'b0;
    SetVerifyErr  = 1'b0;
    case (state_q)
      IDLE: begin
        if (Execute) begin
          cnt_d   = START_CNT;
          state_d = ARB;
        end else begin
          state_d = IDLE;
        end
      end
      ARB: begin
        if (cnt_q == 2'd0) begin
          case (xfer_e'(XferType))
            XFER_STASH:  state_d = STASH;
            XFER_FETCH:  state_d = F_RD;
            XFER_SWAP:   state_d = S_RD;
            XFER_VERIFY: state_d = V_RD;
            default:     state_d = IDLE;
          endcase
        end else begin
          cnt_d = cnt_q - 2'd1;
        end
      end
      STASH: begin
        if (BA) begin
          RAMWR   = 1'b1;
          IncCA   = 1'b1;
          IncREUA = 1'b1;
          DecLen  = 1'b1;
          if (Length1) begin
            XferEnd       = 1'b1;
            SetEndOfBlock = 1'b1;
            state_d       = IDLE;
          end else begin
            state_d = STASH;
          end
        end else begin
          state_d = state_q;
        end
      end
      F_RD: begin
        if (BA) begin
          RAMRD   = 1'b1;
          IncREUA = 1'b1;
          state_d = F_WR;
        end else begin
          state_d = state_q;
        end
      end
      F_WR: begin
        if (BA) begin
          nWEDMA = 1'b0;
          IncCA  = 1'b1;
          DecLen = 1'b1;
          // Prefetch the next byte while the current one goes out on the bus.
          if (!Length1) begin
            RAMRD   = 1'b1;
            IncREUA = 1'b1;
            state_d = F_WR;
          end else begin
            XferEnd       = 1'b1;
            SetEndOfBlock = 1'b1;
            state_d       = IDLE;
          end
        end else begin
          state_d = state_q;
        end
      end
      S_RD: begin
        if (BA) begin
          RAMRD   = 1'b1;
          state_d = S_ST;
        end else begin
          state_d = state_q;
        end
      end
      S_ST: begin
        if (BA) begin
          RAMWR   = 1'b1;
          state_d = S_WR;
        end else begin
          state_d = state_q;
        end
      end
      S_WR: begin
        if (BA) begin
          nWEDMA  = 1'b0;
          IncCA   = 1'b1;
          IncREUA = 1'b1;
          DecLen  = 1'b1;
          if (Length1) begin
            XferEnd       = 1'b1;
            SetEndOfBlock = 1'b1;
            state_d       = IDLE;
          end else begin
            state_d = S_RD;
          end
        end else begin
          state_d = state_q;
        end
      end
      V_RD: begin
        if (BA) begin
          RAMRD   = 1'b1;
          state_d = V_CMP;
        end else begin
          state_d = state_q;
        end
      end
      V_CMP: begin
        if (BA) begin
          IncCA   = 1'b1;
          IncREUA = 1'b1;
          DecLen  = 1'b1;
          if (!Match) begin
            SetVerifyErr  = 1'b1;
            XferEnd       = 1'b1;
            SetEndOfBlock = Length1;
            state_d       = IDLE;
          end else if (Length1) begin
            XferEnd       = 1'b1;
            SetEndOfBlock = 1'b1;
            state_d       = IDLE;
          end else begin
            state_d = V_RD;
          end
        end else begin
          state_d = state_q;
        end
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_reu_dma_sequencer.sv
// Directed bench for reu_dma_sequencer: each step drives inputs mid-cycle and
// checks the full output vector against a hand-computed value.
module tb_reu_dma_sequencer;

  logic       PHI2 = 1'b0;
  logic       nRESET, BA, Execute, Length1, Match;
  logic [1:0] XferType;
  logic       RAMRD, RAMWR, DMA, nWEDMA, RegReset;
  logic       IncCA, IncREUA, DecLen, XferEnd, SetEndOfBlock, SetVerifyErr;

  int total = 0;
  int bad   = 0;

  // Output vector bit masks.
  localparam logic [10:0] RD  = 11'b100_0000_0000;
  localparam logic [10:0] WR  = 11'b010_0000_0000;
  localparam logic [10:0] DM  = 11'b001_0000_0000;
  localparam logic [10:0] NW  = 11'b000_1000_0000;
  localparam logic [10:0] RR  = 11'b000_0100_0000;
  localparam logic [10:0] ICA = 11'b000_0010_0000;
  localparam logic [10:0] IRA = 11'b000_0001_0000;
  localparam logic [10:0] DL  = 11'b000_0000_1000;
  localparam logic [10:0] XE  = 11'b000_0000_0100;
  localparam logic [10:0] EB  = 11'b000_0000_0010;
  localparam logic [10:0] VE  = 11'b000_0000_0001;

  reu_dma_sequencer #(.START_DELAY(1)) dut (
    .PHI2(PHI2), .nRESET(nRESET), .BA(BA), .Execute(Execute),
    .XferType(XferType), .Length1(Length1), .Match(Match),
    .RAMRD(RAMRD), .RAMWR(RAMWR), .DMA(DMA), .nWEDMA(nWEDMA),
    .RegReset(RegReset), .IncCA(IncCA), .IncREUA(IncREUA), .DecLen(DecLen),
    .XferEnd(XferEnd), .SetEndOfBlock(SetEndOfBlock), .SetVerifyErr(SetVerifyErr)
  );

  always #5 PHI2 = ~PHI2;

  task automatic check(input string tag, input logic [10:0] exp);
    logic [10:0] obs;
    obs = {RAMRD, RAMWR, DMA, nWEDMA, RegReset, IncCA, IncREUA, DecLen,
           XferEnd, SetEndOfBlock, SetVerifyErr};
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  // One bus cycle: drive inputs at the falling edge, check shortly after.
  task automatic cyc(input string tag, input logic exe, input logic ba,
                     input logic l1, input logic m, input logic [10:0] exp);
    @(negedge PHI2);
    Execute = exe;
    BA      = ba;
    Length1 = l1;
    Match   = m;
    #1;
    check(tag, exp);
  endtask

  initial begin
    nRESET = 1'b0; BA = 1'b1; Execute = 1'b0; XferType = 2'b00;
    Length1 = 1'b0; Match = 1'b1;

    cyc("rst0", 1'b0, 1'b1, 1'b0, 1'b1, NW | RR);
    cyc("rst1", 1'b0, 1'b1, 1'b0, 1'b1, NW | RR);
    nRESET = 1'b1;
    #1 check("rel_pre_edge", NW | RR);
    cyc("idle_after_rel", 1'b0, 1'b1, 1'b0, 1'b1, NW);

    // Stash, 3 bytes, with a stray Execute in the middle.
    XferType = 2'b00;
    cyc("st_exe",   1'b1, 1'b1, 1'b0, 1'b1, NW);
    cyc("st_arb",   1'b0, 1'b1, 1'b0, 1'b1, DM | NW);
    cyc("st_b1",    1'b0, 1'b1, 1'b0, 1'b1, DM | NW | WR | ICA | IRA | DL);
    cyc("st_b2",    1'b1, 1'b1, 1'b0, 1'b1, DM | NW | WR | ICA | IRA | DL);
    cyc("st_b3",    1'b0, 1'b1, 1'b1, 1'b1, DM | NW | WR | ICA | IRA | DL | XE | EB);
    cyc("st_done",  1'b0, 1'b1, 1'b0, 1'b1, NW);
    cyc("st_noexe", 1'b0, 1'b1, 1'b0, 1'b1, NW);

    // Fetch, 2 bytes, BA low during the second F_WR.
    XferType = 2'b01;
    cyc("f_exe",   1'b1, 1'b1, 1'b0, 1'b1, NW);
    cyc("f_arb",   1'b0, 1'b1, 1'b0, 1'b1, DM | NW);
    cyc("f_rd",    1'b0, 1'b1, 1'b0, 1'b1, DM | NW | RD | IRA);
    cyc("f_wr1",   1'b0, 1'b1, 1'b0, 1'b1, DM | RD | IRA | ICA | DL);
    cyc("f_stall", 1'b0, 1'b0, 1'b1, 1'b1, DM | NW);
    cyc("f_wr2",   1'b0, 1'b1, 1'b1, 1'b1, DM | ICA | DL | XE | EB);
    cyc("f_done",  1'b0, 1'b1, 1'b0, 1'b1, NW);

    // Swap, 1 byte.
    XferType = 2'b10;
    cyc("s_exe",  1'b1, 1'b1, 1'b0, 1'b1, NW);
    cyc("s_arb",  1'b0, 1'b1, 1'b0, 1'b1, DM | NW);
    cyc("s_rd",   1'b0, 1'b1, 1'b1, 1'b1, DM | NW | RD);
    cyc("s_st",   1'b0, 1'b1, 1'b1, 1'b1, DM | NW | WR);
    cyc("s_wr",   1'b0, 1'b1, 1'b1, 1'b1, DM | ICA | IRA | DL | XE | EB);
    cyc("s_done", 1'b0, 1'b1, 1'b0, 1'b1, NW);

    // Verify, 4 bytes, mismatch on byte 2.
    XferType = 2'b11;
    cyc("v_exe",  1'b1, 1'b1, 1'b0, 1'b1, NW);
    cyc("v_arb",  1'b0, 1'b1, 1'b0, 1'b1, DM | NW);
    cyc("v_rd1",  1'b0, 1'b1, 1'b0, 1'b1, DM | NW | RD);
    cyc("v_cmp1", 1'b0, 1'b1, 1'b0, 1'b1, DM | NW | ICA | IRA | DL);
    cyc("v_rd2",  1'b0, 1'b1, 1'b0, 1'b1, DM | NW | RD);
    cyc("v_cmp2", 1'b0, 1'b1, 1'b0, 1'b0, DM | NW | ICA | IRA | DL | VE | XE);
    cyc("v_done", 1'b0, 1'b1, 1'b0, 1'b1, NW);

    // Reset asserted mid-fetch takes effect without a clock edge.
    XferType = 2'b01;
    cyc("r_exe", 1'b1, 1'b1, 1'b0, 1'b1, NW);
    cyc("r_arb", 1'b0, 1'b1, 1'b0, 1'b1, DM | NW);
    cyc("r_rd",  1'b0, 1'b1, 1'b0, 1'b1, DM | NW | RD | IRA);
    cyc("r_wr",  1'b0, 1'b1, 1'b0, 1'b1, DM | RD | IRA | ICA | DL);
    #1 nRESET = 1'b0;
    #1 check("r_async", NW | RR);
    cyc("r_held", 1'b0, 1'b1, 1'b0, 1'b1, NW | RR);
    nRESET = 1'b1;
    cyc("r_idle", 1'b0, 1'b1, 1'b0, 1'b1, NW);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
